// File: rtl/rv_fifo.sv
// rv_fifo: parametrised valid/ready elastic FIFO with occupancy, almost-full and flush.
// Optional zero-latency empty bypass enabled by defining RV_FIFO_BYPASS_EN.
module rv_fifo #(
   parameter int DW        = 32,
   parameter int DEPTH     = 4,
   parameter int AFULL_THR = DEPTH - 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DW-1:0]                in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DW-1:0]                out_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         almost_full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   // Handshake: a transfer happens on a posedge where valid & ready are both high;
   // in_ready never depends on out_ready, so a full FIFO admits nothing even while popping.

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic          init_done;
   logic          empty;
   logic          full;
   logic          push;
   logic          pop;
   logic          wr_en;
   logic          rd_en;

   assign empty       = (count_q == '0);
   assign full        = (count_q == CW'(DEPTH));
   assign in_ready    = init_done & ~full;
   assign push        = in_valid & in_ready;
   assign pop         = out_valid & out_ready;
   assign count       = count_q;
   assign almost_full = (count_q >= CW'(AFULL_THR));

`ifdef RV_FIFO_BYPASS_EN
   // When empty the producer is seen directly; an item taken on the same edge is never stored.
   assign out_valid = empty ? (in_valid & init_done) : 1'b1;
   assign out_data  = empty ? (out_valid ? in_data : '0) : mem[rd_ptr];
   assign wr_en     = push & ~(empty & out_ready);
   assign rd_en     = pop & ~empty;
`else
   assign out_valid = ~empty;
   assign out_data  = empty ? '0 : mem[rd_ptr];
   assign wr_en     = push;
   assign rd_en     = pop;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_done <= 1'b0;
      end else begin
         init_done <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage is deliberately left unreset; out_data is masked while empty.
   always_ff @(posedge clk) begin
      if (wr_en && !flush) begin
         mem[wr_ptr] <= in_data;
      end
   end

endmodule

// File: tb/tb_rv_fifo.sv
// Self-checking bench for rv_fifo: directed scenarios plus random traffic against a queue model.
module tb_rv_fifo;

   localparam int DW        = 32;
   localparam int DEPTH     = 4;
   localparam int AFULL_THR = DEPTH - 1;
   localparam int CW        = $clog2(DEPTH+1);

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] count;
   logic          almost_full;

   int checks = 0;
   int errors = 0;

   // reference model: queue of held items plus init flag
   logic [DW-1:0] exp_q[$];
   bit            exp_init   = 0;
   bit            hs_pending = 0;
   logic [DW-1:0] hs_data    = '0;
   bit            acc        = 0;

   rv_fifo #(.DW(DW), .DEPTH(DEPTH), .AFULL_THR(AFULL_THR)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count), .almost_full(almost_full)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model update on the same events that move the DUT
   initial begin
      int  sz;
      bit  e_ready;
      bit  do_push;
      bit  do_pop;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            exp_q.delete();
            exp_init   = 0;
            hs_pending = 0;
         end else begin
            sz         = exp_q.size();
            e_ready    = exp_init && (sz != DEPTH);
            hs_pending = in_valid && !e_ready;
            hs_data    = in_data;
            if (flush) begin
               exp_q.delete();
            end else begin
               do_push = in_valid && e_ready;
               do_pop  = out_ready && (sz != 0);
`ifdef RV_FIFO_BYPASS_EN
               if (sz == 0 && do_push && out_ready) do_push = 0;
`endif
               if (do_pop)  void'(exp_q.pop_front());
               if (do_push) exp_q.push_back(in_data);
            end
            exp_init = 1;
         end
      end
   end

   // monitor: compare DUT outputs with the model away from the active edge
   always @(negedge clk) begin
      int            sz;
      bit            e_valid;
      logic [DW-1:0] e_data;
      if (!rst_n) begin
         chk("rst_in_ready", in_ready, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_count", count, 0);
         chk("rst_almost_full", almost_full, 0);
         chk("rst_out_data", out_data, 0);
      end else begin
         sz      = exp_q.size();
         e_valid = (sz != 0);
         e_data  = (sz != 0) ? exp_q[0] : '0;
`ifdef RV_FIFO_BYPASS_EN
         if (sz == 0 && in_valid && exp_init) begin
            e_valid = 1;
            e_data  = in_data;
         end
`endif
         chk("in_ready", in_ready, exp_init && (sz != DEPTH));
         chk("out_valid", out_valid, e_valid);
         chk("out_data", out_data, e_data);
         chk("count", count, sz);
         chk("almost_full", almost_full, sz >= AFULL_THR);
         if (hs_pending) begin
            chk("env_valid_held", in_valid, 1);
            chk("env_data_stable", in_data, hs_data);
         end
      end
   end

   // driver tasks
   task automatic cycle();
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [DW-1:0] d, input string name);
      in_valid = 1;
      in_data  = d;
      cycle();
      chk(name, acc, 1);
      in_valid = 0;
   endtask

   task automatic drain();
      in_valid  = 0;
      out_ready = 1;
      repeat (DEPTH + 2) cycle();
   endtask

   initial begin
      bit got;
      rst_n     = 0;
      flush     = 0;
      in_valid  = 1;
      in_data   = 32'h11;
      out_ready = 0;

      // reset / init: in_valid held through reset, accepted only after init
      repeat (5) @(posedge clk);
      #1 rst_n = 1;
      got = 0;
      for (int i = 0; i < 5 && !got; i++) begin
         cycle();
         got = acc;
      end
      chk("reset_push_accepted", got, 1);
      drain();

      // fill / drain with one item held back
      out_ready = 0;
      for (int i = 0; i < DEPTH; i++) push_one(32'hA0 + i, "fill_accept");
      in_valid = 1;
      in_data  = 32'hA4;
      repeat (2) cycle();
      chk("fill_a4_held", acc, 0);
      out_ready = 1;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         cycle();
         got = acc;
      end
      chk("fill_a4_accepted", got, 1);
      drain();

      // full with simultaneous pop: push rejected, then accepted next cycle
      out_ready = 0;
      for (int i = 0; i < DEPTH; i++) push_one(32'hB0 + i, "full_fill_accept");
      in_valid  = 1;
      in_data   = 32'hB4;
      out_ready = 1;
      cycle();
      chk("full_pop_push_rejected", acc, 0);
      out_ready = 0;
      cycle();
      chk("full_push_next_cycle", acc, 1);
      drain();

      // streaming wrap-around
      out_ready = 1;
      for (int i = 1; i <= 10; i++) push_one(i, "stream_accept");
      drain();

      // flush with data presented in the same cycle
      out_ready = 0;
      for (int i = 0; i < 3; i++) push_one(32'hC0 + i, "flush_fill_accept");
      in_valid = 1;
      in_data  = 32'h55;
      flush    = 1;
      cycle();
      flush    = 0;
      in_valid = 0;
      @(negedge clk);
      chk("flush_count", count, 0);
      chk("flush_out_valid", out_valid, 0);
      chk("flush_out_data", out_data, 0);
      @(posedge clk);
      #1;
      drain();

      // async reset between edges
      out_ready = 0;
      for (int i = 0; i < 2; i++) push_one(32'hD0 + i, "areset_fill_accept");
      #2 rst_n = 0;
      #1;
      chk("areset_out_valid", out_valid, 0);
      chk("areset_count", count, 0);
      chk("areset_in_ready", in_ready, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      cycle();

      // random traffic obeying the producer rules
      acc      = 1;
      in_valid = 0;
      for (int i = 0; i < 400; i++) begin
         if (!(in_valid && !acc)) begin
            if ($urandom_range(0, 99) < 60) begin
               in_valid = 1;
               in_data  = $urandom;
            end else begin
               in_valid = 0;
            end
         end
         out_ready = ($urandom_range(0, 99) < 55);
         flush     = ($urandom_range(0, 39) == 0);
         cycle();
      end
      flush = 0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
